// File: rtl/ram_arb_pkg.sv
// Shared constants and state encoding for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned RAM_ADDR_W = 5;
  localparam int unsigned RAM_DATA_W = 32;
  localparam int unsigned RAM_DEPTH  = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    CLEAR   = 2'd3
  } state_e;

endpackage

// File: rtl/ram_arb_rr2.sv
// Combinational 2-way round-robin picker: on a tie the port that was not
// granted last wins.
module ram_arb_rr2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant     = '0;
    grant[0]  = req[0] & (~req[1] | (last_gnt == PORT1));
    grant[1]  = req[1] & (~req[0] | (last_gnt == PORT0));
    grant_idx = grant[1] ? PORT1 : PORT0;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin controller for a single-port synchronous RAM.
// Optional power-up zero sweep: RAM_ARBITER_INIT_CLEAR_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W,
  parameter int unsigned DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rd_data,
  output logic              init_done,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  if (DEPTH > (1 << ADDR_W)) begin : g_depth_chk
    $error("DEPTH exceeds the address space");
  end

  state_e              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic                cur_port_q, cur_port_d;
  logic                cur_wr_q, cur_wr_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                ram_cen_q, ram_cen_d, ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
`ifdef RAM_ARBITER_INIT_CLEAR_EN
  logic                init_done_q, init_done_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
`endif

  logic [1:0]          pick;
  logic                pick_idx;
  logic                sel_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  ram_arb_rr2 u_rr2 (
    .req       ({req1, req0}),
    .last_gnt  (last_gnt_q),
    .grant     (pick),
    .grant_idx (pick_idx)
  );

  assign sel_wr    = (pick_idx == PORT1) ? wr1    : wr0;
  assign sel_addr  = (pick_idx == PORT1) ? addr1  : addr0;
  assign sel_wdata = (pick_idx == PORT1) ? wdata1 : wdata0;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cur_port_d = cur_port_q;
    cur_wr_d   = cur_wr_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rd_data_d  = rd_data_q;
    ram_cen_d  = 1'b0;
    ram_wen_d  = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
`ifdef RAM_ARBITER_INIT_CLEAR_EN
    init_done_d = init_done_q;
    clr_cnt_d   = clr_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|pick) begin
          gnt0_d     = pick[0];
          gnt1_d     = pick[1];
          ram_cen_d  = 1'b1;
          ram_wen_d  = sel_wr;
          ram_addr_d = sel_addr;
          ram_din_d  = sel_wr ? sel_wdata : '0;
          last_gnt_d = pick_idx;
          cur_port_d = pick_idx;
          cur_wr_d   = sel_wr;
          state_d    = ACCESS;
        end
      end
      ACCESS: state_d = cur_wr_q ? IDLE : CAPTURE;
      CAPTURE: begin
        rd_data_d = ram_dout;
        rvalid0_d = (cur_port_q == PORT0);
        rvalid1_d = (cur_port_q == PORT1);
        state_d   = IDLE;
      end
`ifdef RAM_ARBITER_INIT_CLEAR_EN
      CLEAR: begin
        // Last sweep write is recognised from the registered RAM command,
        // so the IDLE hand-over lands one edge after address DEPTH-1 issues.
        if (ram_cen_q && (ram_addr_q == ADDR_W'(DEPTH - 1))) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          ram_cen_d  = 1'b1;
          ram_wen_d  = 1'b1;
          ram_addr_d = clr_cnt_q;
          ram_din_d  = '0;
          clr_cnt_d  = clr_cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
`ifdef RAM_ARBITER_INIT_CLEAR_EN
      state_q     <= CLEAR;
      init_done_q <= 1'b0;
      clr_cnt_q   <= '0;
`else
      state_q     <= IDLE;
`endif
      last_gnt_q <= PORT1;
      cur_port_q <= PORT0;
      cur_wr_q   <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rd_data_q  <= '0;
      ram_cen_q  <= 1'b0;
      ram_wen_q  <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
`ifdef RAM_ARBITER_INIT_CLEAR_EN
      init_done_q <= init_done_d;
      clr_cnt_q   <= clr_cnt_d;
`endif
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cur_port_q <= cur_port_d;
      cur_wr_q   <= cur_wr_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rd_data_q  <= rd_data_d;
      ram_cen_q  <= ram_cen_d;
      ram_wen_q  <= ram_wen_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rd_data  = rd_data_q;
  assign ram_cen  = ram_cen_q;
  assign ram_wen  = ram_wen_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
`ifdef RAM_ARBITER_INIT_CLEAR_EN
  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 32x32 synchronous RAM.
// Honours RAM_ARBITER_INIT_CLEAR_EN when compiled with it.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [4:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, init_done;
  logic [31:0] rd_data;
  logic        ram_cen, ram_wen;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = '0;
  logic [31:0] mem [0:31];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];

`ifdef RAM_ARBITER_INIT_CLEAR_EN
  localparam logic        INIT_AT_RESET = 1'b0;
  localparam logic [31:0] EXP_ADDR9     = 32'h0;
`else
  localparam logic        INIT_AT_RESET = 1'b1;
  localparam logic [31:0] EXP_ADDR9     = 32'h99;
`endif

  ram_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0      (req0),
    .req1      (req1),
    .wr0       (wr0),
    .wr1       (wr1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rd_data   (rd_data),
    .init_done (init_done),
    .ram_cen   (ram_cen),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_cen) begin
      if (ram_wen) begin
        mem[ram_addr] <= ram_din;
        ram_dout      <= '0;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end else begin
      ram_dout <= '0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every grant / read-valid pulse must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (gnt0 || gnt1) begin
      if (gq.size() == 0) begin
        check("gnt_unexpected", 64'({gnt1, gnt0}), 64'(0));
      end else begin
        e = gq.pop_front();
        check("gnt_port", 64'({gnt1, gnt0}), (e.port == 1) ? 64'(2'b10) : 64'(2'b01));
        check("gnt_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (rvalid0 || rvalid1) begin
      if (rq.size() == 0) begin
        check("rvalid_unexpected", 64'({rvalid1, rvalid0}), 64'(0));
      end else begin
        e = rq.pop_front();
        check("rvalid_port", 64'({rvalid1, rvalid0}), (e.port == 1) ? 64'(2'b10) : 64'(2'b01));
        check("rd_data", 64'(rd_data), 64'(e.data));
        check("rvalid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [4:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0 = r; wr0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; wr1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // Called just after a negedge with the arbiter idle; returns at a negedge.
  task automatic do_access(input int p, input logic w, input logic [4:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd);
    drive(p, 1'b1, w, a, d);
    gq.push_back('{p, 32'h0, cyc + 1});
    if (!w) rq.push_back('{p, exp_rd, cyc + 3});
    @(negedge clk);
    drive(p, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1;
    check("reset_ctrl", 64'({gnt0, gnt1, rvalid0, rvalid1, ram_cen, ram_wen, ram_addr}), 64'(0));
    check("reset_data", {ram_din, rd_data}, 64'(0));
    check("reset_init_done", 64'(init_done), 64'(INIT_AT_RESET));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
`ifdef RAM_ARBITER_INIT_CLEAR_EN
    begin
      int k;
      for (k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (init_done) break;
      end
      check("clear_edges", 64'(k), 64'(33));
    end
`else
    check("init_done_release", 64'(init_done), 64'(1));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1, 1'b0, 1'b0, 5'd0, 32'h0);
    reset_pulse();
  endtask

  initial begin
    int c;

    // Write then read back on port 0; the write is issued in the first cycle after reset.
    do_reset();
    do_access(0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0);
    do_access(0, 1'b0, 5'd5, 32'h0, 32'hDEADBEEF);

    // Both ports held: strict alternation 0,1,0,1.
    do_reset();
    do_access(0, 1'b1, 5'd1, 32'h11, 32'h0);
    do_access(1, 1'b1, 5'd2, 32'h22, 32'h0);
    drive(0, 1'b1, 1'b0, 5'd1, 32'h0);
    drive(1, 1'b1, 1'b0, 5'd2, 32'h0);
    c = cyc;
    gq.push_back('{0, 32'h0, c + 1});
    rq.push_back('{0, 32'h11, c + 3});
    gq.push_back('{1, 32'h0, c + 4});
    rq.push_back('{1, 32'h22, c + 6});
    gq.push_back('{0, 32'h0, c + 7});
    rq.push_back('{0, 32'h11, c + 9});
    gq.push_back('{1, 32'h0, c + 10});
    rq.push_back('{1, 32'h22, c + 12});
    repeat (10) @(negedge clk);
    drive(0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (4) @(negedge clk);

    // Read and write of the same address collide; the read sees the old value.
    do_reset();
    do_access(1, 1'b1, 5'd3, 32'h33, 32'h0);
    drive(0, 1'b1, 1'b0, 5'd3, 32'h0);
    drive(1, 1'b1, 1'b1, 5'd3, 32'h77);
    c = cyc;
    gq.push_back('{0, 32'h0, c + 1});
    rq.push_back('{0, 32'h33, c + 3});
    gq.push_back('{1, 32'h0, c + 4});
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (3) @(negedge clk);
    drive(1, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    do_access(0, 1'b0, 5'd3, 32'h0, 32'h77);

    // Reset during the ACCESS cycle of a read: no rvalid may follow.
    do_access(0, 1'b1, 5'd9, 32'h99, 32'h0);
    drive(0, 1'b1, 1'b0, 5'd9, 32'h0);
    gq.push_back('{0, 32'h0, cyc + 1});
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 5'd0, 32'h0);
    reset_pulse();
    repeat (5) @(negedge clk);
    do_access(0, 1'b0, 5'd9, 32'h0, EXP_ADDR9);

`ifdef RAM_ARBITER_INIT_CLEAR_EN
    // Request held through the sweep is only granted once IDLE is reached.
    do_access(0, 1'b1, 5'd31, 32'hA5A5A5A5, 32'h0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 5'd31, 32'h0);
    reset_pulse();
    gq.push_back('{0, 32'h0, cyc + 1});
    rq.push_back('{0, 32'h0, cyc + 3});
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (3) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    check("gnt_queue_drained", 64'(gq.size()), 64'(0));
    check("rvalid_queue_drained", 64'(rq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester controller that shares the single-port 32x32 synchronous RAM (clk, cen, wen, addr[4:0], din[31:0], dout[31:0]).
- Sits between two masters (for example a datapath and a loader/debug port) and the RAM instance.
- Arbitrates round-robin, sequences each access, captures read data and returns it to the requester with a valid pulse.
- Drives every RAM control input from registers.

Parameters:
- ADDR_W, 5, RAM address width; fixed by the 32-entry RAM.
- DATA_W, 32, RAM data width.
- DEPTH, 32, number of RAM words; used only by the clear sequence.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1  access request from port 0 / port 1.
- wr0, wr1  in  1  1 = write, 0 = read; valid while reqN is high.
- addr0, addr1  in  ADDR_W  access address.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  one-cycle pulse: request accepted.
- rvalid0, rvalid1  out  1  one-cycle pulse: rd_data holds this port's read result.
- rd_data  out  DATA_W  read data, shared by both ports.
- init_done  out  1  high when the arbiter accepts requests.
- ram_cen, ram_wen  out  1  to RAM cen/wen.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_din  out  DATA_W  to RAM din.
- ram_dout  in  DATA_W  from RAM dout.

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0 except init_done; state=IDLE (or CLEAR, see Optional Feature); last_gnt=1, so port 0 wins the first tie.
- Reset asserted mid-operation: the in-flight access is abandoned. No gnt or rvalid is issued for it. A RAM write already sampled by the RAM may complete.
- States: IDLE, ACCESS, CAPTURE (plus CLEAR when the feature is compiled in).
- IDLE:
  - If any req is high, pick the winner. If only one port requests, it wins. If both request, the port that is not last_gnt wins.
  - Register gnt for the winner, ram_cen=1, ram_wen=wrN, ram_addr=addrN, ram_din=wdataN (0 for reads). Update last_gnt. Go to ACCESS.
  - With no request: ram_cen=0, ram_wen=0.
- ACCESS (the RAM performs the operation at this edge):
  - Requests are not sampled. gnt returns to 0 and ram_cen/ram_wen return to 0.
  - A write goes to IDLE. A read goes to CAPTURE.
- CAPTURE:
  - rd_data <= ram_dout; rvalid for the granted port = 1 for one cycle. Go to IDLE.
  - rd_data holds its value until the next capture.
- Requester rule: hold reqN, wrN, addrN and wdataN stable until gnt is seen. Deassert req on the edge after gnt, or keep it high to request again.
- Throughput and latency, counted from the edge at which IDLE samples req:
  - Write: one access every 2 cycles; the data is in RAM after the 2nd edge.
  - Read: one access every 3 cycles; rvalid is high in the cycle after the 3rd edge.
- Simultaneous requests with continuous demand strictly alternate 0,1,0,1.
- ram_cen is 0 whenever the RAM is idle, so the RAM's dout reads 0 outside a read. Capture is taken only in CAPTURE.
- Addresses wrap naturally at ADDR_W; no range checking.

Optional Feature:
- Macro: RAM_ARBITER_INIT_CLEAR_EN.
- Defined:
  - After reset release, the state is CLEAR and init_done=0.
  - A 5-bit counter writes 0 to addresses 0..DEPTH-1, one per cycle (ram_cen=1, ram_wen=1, ram_din=0).
  - After address DEPTH-1 the state goes to IDLE and init_done=1 (33rd edge).
  - Requests are ignored during CLEAR; no gnt.
  - A reset during CLEAR restarts the sweep from address 0.
- Not defined: no CLEAR state or counter; init_done is constant 1; IDLE is entered directly from reset.

Decomposition:
- Package ram_arb_pkg: state encoding (IDLE, ACCESS, CAPTURE, CLEAR), ADDR_W/DATA_W/DEPTH constants, port-index constants.
- Sub-module ram_arb_rr2: combinational 2-way round-robin picker. Inputs req[1:0], last_gnt; outputs grant one-hot and grant index. All state stays in ram_arbiter.

Test Plan:
- Port 0 write, addr=5, wdata=0xDEADBEEF; then port 0 read, addr=5 -> gnt0 pulse; rvalid0 high with rd_data=0xDEADBEEF 3 edges after the read request; gnt1 and rvalid1 stay 0.
- req0 and req1 both held high, reads of addr 1/addr 2 preloaded 0x11/0x22 -> grants in order port 0, 1, 0, 1; rvalid0 with 0x11 and rvalid1 with 0x22 alternate; no lost or duplicated grant.
- Port 0 read of addr 3 and port 1 write of addr 3 value 0x77 requested in the same cycle -> read wins, rd_data=old value; a following port 0 read returns 0x77.
- reset_n pulled low during ACCESS of a read -> all outputs 0 immediately; no rvalid after release; the next request is serviced normally.
- With RAM_ARBITER_INIT_CLEAR_EN defined, RAM preloaded with nonzero data, req0 high during reset release -> no gnt0 for 32 cycles; init_done rises at the 33rd edge; a read of addr 31 returns 0.
- With the macro undefined -> init_done=1 from the first cycle after reset; a request in that cycle is granted.
